matrix_multiplier: RTL and testbench

//  Streaming signed matrix multiplier C[N][M] = A[N][P] x B[P][M] fed by an external memory.
//  The block requests one row of A or one column of B at a time over a fetch/stall handshake.
//  It computes one dot product per C element with a sequential MAC.

---
 rtl/matrix_multiplier_pkg.sv | 24 ++
 rtl/mm_result_fifo.sv | 74 +++++++
 rtl/matrix_multiplier.sv | 192 +++++++++++++++++++
 tb/tb_matrix_multiplier.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_multiplier_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
// The FSM state enum is visible to anything that imports this package.
package matrix_multiplier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_ROW = 3'd1,
        ST_WAIT_ROW  = 3'd2,
        ST_FETCH_COL = 3'd3,
        ST_WAIT_COL  = 3'd4,
        ST_COMPUTE   = 3'd5
    } mm_state_e;

    // Index width for a counter over `count` items; never narrower than one bit.
    function automatic int mm_idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Width of an occupancy counter that must hold the values 0..count.
    function automatic int mm_cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/mm_result_fifo.sv
// Show-ahead result FIFO: the head is visible while not empty and reads as 0 when empty.
// Illegal pops (empty) and pushes (full) are dropped and raise a sticky error flag.
module mm_result_fifo
    import matrix_multiplier_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PTR_W = mm_idx_width(DEPTH);
    localparam int CNT_W = mm_cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if ((push && full) || (pop && empty)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/matrix_multiplier.sv
// Streaming signed C = A x B: fetches one row of A, then each column of B in turn,
// computes every C element with a sequential MAC and queues results row-major in a FIFO.
module matrix_multiplier
    import matrix_multiplier_pkg::*;
#(
    parameter  int N           = 2,
    parameter  int P           = 2,
    parameter  int M           = 2,
    parameter  int DATA_WIDTH  = 4,
    parameter  int ACCUM_WIDTH = 8,
    parameter  int FIFO_SIZE   = 4,
    localparam int N_BIT_WIDTH = mm_idx_width(N),
    localparam int M_BIT_WIDTH = mm_idx_width(M)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_stall,
    input  logic                          data_stall,
    input  logic                          pop_fifo,
    input  logic                          start,
    input  logic signed [DATA_WIDTH-1:0]  mem_line [0:N-1],
    output logic [N_BIT_WIDTH-1:0]        n,
    output logic [M_BIT_WIDTH-1:0]        m,
    output logic                          fetch_row,
    output logic                          fetch_col,
    output logic [ACCUM_WIDTH-1:0]        fifo_head,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          done,
    output logic                          err
);

    // Memory handshake: a fetch_row/fetch_col pulse is a request that is taken in any
    // cycle where fetch_stall is low (the request is only raised then); afterwards
    // mem_line is consumed on the first cycle data_stall is low, and never before.

    localparam int K_W = mm_idx_width(P);

    mm_state_e state_q;
    mm_state_e state_d;

    logic [N_BIT_WIDTH-1:0]        n_q;
    logic [M_BIT_WIDTH-1:0]        m_q;
    logic signed [DATA_WIDTH-1:0]  row_q [0:P-1];
    logic signed [DATA_WIDTH-1:0]  col_q [0:P-1];
    logic signed [ACCUM_WIDTH-1:0] acc_q;
    logic [K_W-1:0]                k_q;
    logic                          last_q;
    logic                          row_end_q;

    logic                          load_row;
    logic                          start_pe;
    logic                          push;
    logic                          last_k;
    logic                          m_at_end;
    logic                          n_at_end;
    logic signed [ACCUM_WIDTH-1:0] row_ext;
    logic signed [ACCUM_WIDTH-1:0] col_ext;
    logic signed [ACCUM_WIDTH-1:0] mac_sum;

    assign n        = n_q;
    assign m        = m_q;
    assign last_k   = (k_q == K_W'(P - 1));
    assign m_at_end = (m_q == M_BIT_WIDTH'(M - 1));
    assign n_at_end = (n_q == N_BIT_WIDTH'(N - 1));

    // Operands are sign-extended before the multiply so the sum wraps in ACCUM_WIDTH.
    assign row_ext  = ACCUM_WIDTH'(row_q[k_q]);
    assign col_ext  = ACCUM_WIDTH'(col_q[k_q]);
    assign mac_sum  = acc_q + row_ext * col_ext;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fetch_row = 1'b0;
        fetch_col = 1'b0;
        load_row  = 1'b0;
        start_pe  = 1'b0;
        push      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH_ROW;
                end
            end
            ST_FETCH_ROW: begin
                fetch_row = !fetch_stall;
                if (fetch_row) begin
                    state_d = ST_WAIT_ROW;
                end
            end
            ST_WAIT_ROW: begin
                load_row = !data_stall;
                if (load_row) begin
                    state_d = ST_FETCH_COL;
                end
            end
            ST_FETCH_COL: begin
                fetch_col = !fetch_stall;
                if (fetch_col) begin
                    state_d = ST_WAIT_COL;
                end
            end
            ST_WAIT_COL: begin
                // Only one result is ever in flight, so a free slot now guarantees the push.
                start_pe = !data_stall && !fifo_full;
                if (start_pe) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (last_k) begin
                    push = 1'b1;
                    if (last_q) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (row_end_q) begin
                        state_d = ST_FETCH_ROW;
                    end else begin
                        state_d = ST_FETCH_COL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Indices advance as the PE starts, so n/m already name the next fetch target;
    // last_q/row_end_q remember where the element being computed sits.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            n_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            last_q    <= 1'b0;
            row_end_q <= 1'b0;
            for (int i = 0; i < P; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            if (load_row) begin
                for (int i = 0; i < P; i++) begin
                    row_q[i] <= mem_line[i];
                end
            end
            if (start_pe) begin
                for (int i = 0; i < P; i++) begin
                    col_q[i] <= mem_line[i];
                end
                acc_q     <= '0;
                k_q       <= '0;
                row_end_q <= m_at_end;
                last_q    <= m_at_end && n_at_end;
                if (m_at_end) begin
                    m_q <= '0;
                    n_q <= n_at_end ? '0 : n_q + N_BIT_WIDTH'(1);
                end else begin
                    m_q <= m_q + M_BIT_WIDTH'(1);
                end
            end else if (state_q == ST_COMPUTE) begin
                acc_q <= mac_sum;
                k_q   <= last_k ? '0 : k_q + K_W'(1);
            end
        end
    end

    mm_result_fifo #(
        .WIDTH (ACCUM_WIDTH),
        .DEPTH (FIFO_SIZE)
    ) u_result_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (push),
        .pop   (pop_fifo),
        .din   (mac_sum),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .err   (err)
    );

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed bench for matrix_multiplier: stall walkthrough, full runs against hand-computed
// results, FIFO back-pressure, sticky error and asynchronous reset mid-computation.
module tb_matrix_multiplier;
    import matrix_multiplier_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_stall;
    logic              data_stall;
    logic              pop_fifo;
    logic              start;
    logic signed [3:0] mem_line [0:1];
    logic [0:0]        n;
    logic [0:0]        m;
    logic              fetch_row;
    logic              fetch_col;
    logic [7:0]        fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              done;
    logic              err;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    logic [7:0]        exp_q[$];
    logic signed [3:0] row_tab [0:1][0:1];
    logic signed [3:0] col_tab [0:1][0:1];

    matrix_multiplier dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_stall (fetch_stall),
        .data_stall  (data_stall),
        .pop_fifo    (pop_fifo),
        .start       (start),
        .mem_line    (mem_line),
        .n           (n),
        .m           (m),
        .fetch_row   (fetch_row),
        .fetch_col   (fetch_col),
        .fifo_head   (fifo_head),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .done        (done),
        .err         (err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Loads memory contents (row r of A, column c of B) and the hand-computed C, row-major.
    task automatic set_job(input logic [3:0] r00, input logic [3:0] r01,
                           input logic [3:0] r10, input logic [3:0] r11,
                           input logic [3:0] c00, input logic [3:0] c01,
                           input logic [3:0] c10, input logic [3:0] c11,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        row_tab[0][0] = r00; row_tab[0][1] = r01;
        row_tab[1][0] = r10; row_tab[1][1] = r11;
        col_tab[0][0] = c00; col_tab[0][1] = c01;
        col_tab[1][0] = c10; col_tab[1][1] = c11;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    // One cycle of memory model plus scoreboard-checked consumer.
    task automatic step(input bit rand_stall, input bit drain);
        @(negedge clk);
        fetch_stall = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
        data_stall  = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
        pop_fifo    = drain && !fifo_empty && (!rand_stall || ($urandom_range(0, 1) == 1));
        #1;
        if (pop_fifo) begin
            if (exp_q.size() > 0) check("fifo_head", fifo_head, exp_q.pop_front());
            else                  check("unexpected_result", fifo_head, 32'hDEAD);
        end
        if (fetch_row) for (int k = 0; k < 2; k++) mem_line[k] = row_tab[n][k];
        if (fetch_col) for (int k = 0; k < 2; k++) mem_line[k] = col_tab[m][k];
        if (done) done_cnt++;
    endtask

    task automatic kick(input bit rand_stall, input bit drain);
        start = 1'b1;
        step(rand_stall, drain);
        start = 1'b0;
    endtask

    task automatic run_until(input int target, input bit rand_stall, input bit drain, input int budget);
        int cyc = 0;
        while (cyc < budget &&
               !(done_cnt >= target && (!drain || (exp_q.size() == 0 && fifo_empty)))) begin
            step(rand_stall, drain);
            cyc++;
        end
        check("run_done_count", done_cnt, target);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; pop_fifo = 1'b0;
        fetch_stall = 1'b0; data_stall = 1'b0;
        mem_line[0] = '0; mem_line[1] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_n_idx", n, 0);
        check("rst_m_idx", m, 0);
        check("rst_fetch_row", fetch_row, 0);
        check("rst_fetch_col", fetch_col, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_fifo_head", fifo_head, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // Idle with start low
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0);
            check("idle_fetch", {fetch_row, fetch_col}, 0);
        end
        check("idle_empty", fifo_empty, 1);
        check("idle_done_cnt", done_cnt, 0);

        // Job 1: every row and column reads {1,2}, each C element = 1*1 + 2*2 = 5
        set_job(4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 8'h05, 8'h05, 8'h05, 8'h05);
        start = 1'b1; fetch_stall = 1'b1; data_stall = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        check("stall_fetch_row", fetch_row, 0);
        check("stall_fetch_col", fetch_col, 0);
        check("stall_empty", fifo_empty, 1);
        @(negedge clk); fetch_stall = 1'b0; #1;
        check("fetch_row_go", fetch_row, 1);
        @(negedge clk); fetch_stall = 1'b1; mem_line[0] = 4'sd1; mem_line[1] = 4'sd2; #1;
        check("wait_row_no_fetch", fetch_row, 0);
        check("wait_row_held", dut.load_row, 0);
        @(negedge clk); data_stall = 1'b0; #1;
        check("load_row_go", dut.load_row, 1);
        @(negedge clk); data_stall = 1'b1; #1;
        check("fetch_col_stalled", fetch_col, 0);
        @(negedge clk); fetch_stall = 1'b0; #1;
        check("fetch_col_go", fetch_col, 1);
        @(negedge clk); fetch_stall = 1'b1; #1;
        check("start_pe_held", dut.start_pe, 0);
        @(negedge clk); data_stall = 1'b0; #1;
        check("start_pe_go", dut.start_pe, 1);
        @(negedge clk); data_stall = 1'b1; #1;
        check("adv_m", m, 1);
        check("adv_n", n, 0);
        for (int i = 0; i < 16 && fifo_empty; i++) @(negedge clk);
        #1;
        check("first_push_empty", fifo_empty, 0);
        check("first_head", fifo_head, 8'h05);

        run_until(1, 0, 0, 100);
        repeat (4) step(0, 0);
        check("single_done_pulse", done_cnt, 1);
        check("job1_full", fifo_full, 1);

        // Job 2 is started against a full FIFO and must park before the PE
        // C00=3*2-2*5=-4, C01=3*-3-2*1=-11, C10=-1*2+4*5=18, C11=-1*-3+4*1=7
        set_job(4'h3, 4'hE, 4'hF, 4'h4, 4'h2, 4'h5, 4'hD, 4'h1, 8'hFC, 8'hF5, 8'h12, 8'h07);
        kick(0, 0);
        repeat (12) step(0, 0);
        check("blocked_full", fifo_full, 1);
        check("blocked_state", dut.state_q, ST_WAIT_COL);
        check("blocked_no_done", done_cnt, 1);
        run_until(2, 1, 1, 600);
        check("job2_drained", exp_q.size(), 0);
        check("job2_empty", fifo_empty, 1);

        // Job 3: wrap boundary. C00=64+64=128->80, C01=-56+64=8, C10=-112->90, C11=49-56=-7
        set_job(4'h8, 4'h8, 4'h7, 4'h7, 4'h8, 4'h8, 4'h7, 4'h8, 8'h80, 8'h08, 8'h90, 8'hF9);
        kick(1, 1);
        run_until(3, 1, 1, 600);
        check("job3_drained", exp_q.size(), 0);
        check("err_before_bad_pop", err, 0);

        // Pop on empty is sticky
        @(negedge clk); pop_fifo = 1'b1;
        @(negedge clk); pop_fifo = 1'b0; #1;
        check("err_set", err, 1);
        check("bad_pop_still_empty", fifo_empty, 1);
        repeat (5) step(0, 0);
        check("err_sticky", err, 1);

        // Reset asserted mid-COMPUTE
        set_job(4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 8'h05, 8'h05, 8'h05, 8'h05);
        exp_q.delete();
        kick(0, 0);
        for (int i = 0; i < 20 && dut.state_q != ST_COMPUTE; i++) step(0, 0);
        check("reached_compute", dut.state_q, ST_COMPUTE);
        check("compute_m_advanced", m, 1);
        rst_n = 1'b1;
        #1;
        check("mid_rst_state", dut.state_q, ST_IDLE);
        check("mid_rst_m", m, 0);
        check("mid_rst_n", n, 0);
        check("mid_rst_fetch", {fetch_row, fetch_col}, 0);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_full", fifo_full, 0);
        check("mid_rst_head", fifo_head, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
